// File: rtl/ext_op_pipe.sv
// ext_op_pipe: registered ExtOp decoder with valid/ready handshake, stall and flush.
// Define EXT_ERR_CNT_EN to add the saturating illegal_cnt output.
module ext_op_pipe #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_ext_op,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_illegal
`ifdef EXT_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  illegal_cnt
`endif
);

  localparam logic [1:0] EXT_ZEXT = 2'b00;
  localparam logic [1:0] EXT_SEXT = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] EXT_ILL  = 2'b11;

  // Zero-extending encodings: R-type logic/unsigned ops and the unsigned/logic immediates.
  function automatic logic is_zext(input logic [5:0] op, input logic [5:0] funct);
    logic hit;
    hit = 1'b0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101011, 6'b000000, 6'b000010, 6'b000100, 6'b000110, 6'b001000,
          6'b001001: hit = 1'b1;
          default:   hit = 1'b0;
        endcase
      end
      6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b100100: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Sign-extending encodings: signed compares, branches, arithmetic immediates and loads/stores.
  function automatic logic is_sext(input logic [5:0] op, input logic [4:0] rt,
                                   input logic [5:0] funct);
    logic hit;
    hit = 1'b0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b101010, 6'b000011, 6'b000111: hit = 1'b1;
          default: hit = 1'b0;
        endcase
      end
      6'b000001: begin
        if (rt == 5'b00000 || rt == 5'b00001) begin
          hit = 1'b1;
        end else begin
          hit = 1'b0;
        end
      end
      6'b001001, 6'b001010, 6'b000100, 6'b000101, 6'b000110, 6'b000111,
      6'b100000, 6'b101000, 6'b100011, 6'b101011: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic is_lui(input logic [5:0] op);
    return (op == 6'b001111);
  endfunction

  logic [5:0]        op_s;
  logic [4:0]        rt_s;
  logic [5:0]        funct_s;
  logic [15:0]       imm_s;
  logic [1:0]        kind_s;
  logic [DATA_W-1:0] imm_ext_s;
  logic              accept_s;
  logic              valid_r;
  logic [1:0]        ext_op_r;
  logic [DATA_W-1:0] imm_r;
  logic              illegal_r;
  logic              unused_fields_s;

  assign op_s    = in_instr[31:26];
  assign rt_s    = in_instr[20:16];
  assign funct_s = in_instr[5:0];
  assign imm_s   = in_instr[15:0];
  // rs and shamt never influence the extension mode
  assign unused_fields_s = ^{in_instr[25:21], in_instr[10:6]};

  assign in_ready = !valid_r || out_ready;
  assign accept_s = in_valid && in_ready && !flush;

  // Classify the offered instruction and build its extended immediate
  always_comb begin
    kind_s    = EXT_ILL;
    imm_ext_s = '0;
    if (is_zext(op_s, funct_s)) begin
      kind_s = EXT_ZEXT;
    end else if (is_sext(op_s, rt_s, funct_s)) begin
      kind_s = EXT_SEXT;
    end else if (is_lui(op_s)) begin
      kind_s = EXT_LUI;
    end else begin
      kind_s = EXT_ILL;
    end
    case (kind_s)
      EXT_ZEXT: imm_ext_s[15:0] = imm_s;
      EXT_SEXT: begin
        imm_ext_s       = {DATA_W{imm_s[15]}};
        imm_ext_s[15:0] = imm_s;
      end
      EXT_LUI:  imm_ext_s[DATA_W-1 -: 16] = imm_s;
      default:  imm_ext_s = '0;
    endcase
  end

  // Output register: flush beats accept, accept beats drain, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r   <= 1'b0;
      ext_op_r  <= EXT_ZEXT;
      imm_r     <= '0;
      illegal_r <= 1'b0;
    end else if (flush) begin
      valid_r   <= 1'b0;
    end else if (accept_s) begin
      valid_r   <= 1'b1;
      ext_op_r  <= kind_s;
      imm_r     <= imm_ext_s;
      illegal_r <= (kind_s == EXT_ILL);
    end else if (valid_r && out_ready) begin
      valid_r   <= 1'b0;
    end else begin
      valid_r   <= valid_r;
    end
  end

  assign out_valid   = valid_r;
  assign out_ext_op  = ext_op_r;
  assign out_imm     = imm_r;
  assign out_illegal = illegal_r;

`ifdef EXT_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Saturating count of accepted illegal instructions; flush already masks accept_s
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (accept_s && (kind_s == EXT_ILL) && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign illegal_cnt = cnt_r;
`else
  logic [CNT_W-1:0] unused_cnt_s;
  assign unused_cnt_s = '0;
`endif

endmodule

// File: tb/tb_ext_op_pipe.sv
// Self-checking bench for ext_op_pipe: directed scenarios plus a randomized run
// against a transaction-level reference model (32-bit and 16-bit instances).
module tb_ext_op_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ext_op;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic        in_ready_16;
  logic        out_valid_16;
  logic [1:0]  out_ext_op_16;
  logic [15:0] out_imm_16;
  logic        out_illegal_16;
`ifdef EXT_ERR_CNT_EN
  logic [7:0]  illegal_cnt;
  logic [1:0]  illegal_cnt_sat;
  logic        sat_unused_rdy;
  logic        sat_unused_vld;
  logic [1:0]  sat_unused_op;
  logic [31:0] sat_unused_imm;
  logic        sat_unused_ill;
`endif

  int n_pass  = 0;
  int n_total = 0;

  ext_op_pipe #(.DATA_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_ext_op(out_ext_op), .out_imm(out_imm), .out_illegal(out_illegal)
`ifdef EXT_ERR_CNT_EN
    , .illegal_cnt(illegal_cnt)
`endif
  );

`ifdef EXT_ERR_CNT_EN
  ext_op_pipe #(.DATA_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_16),
    .in_instr(in_instr), .out_valid(out_valid_16), .out_ready(out_ready),
    .out_ext_op(out_ext_op_16), .out_imm(out_imm_16), .out_illegal(out_illegal_16),
    .illegal_cnt()
  );
  ext_op_pipe #(.DATA_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(sat_unused_rdy),
    .in_instr(in_instr), .out_valid(sat_unused_vld), .out_ready(out_ready),
    .out_ext_op(sat_unused_op), .out_imm(sat_unused_imm), .out_illegal(sat_unused_ill),
    .illegal_cnt(illegal_cnt_sat)
  );
`else
  ext_op_pipe #(.DATA_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_16),
    .in_instr(in_instr), .out_valid(out_valid_16), .out_ready(out_ready),
    .out_ext_op(out_ext_op_16), .out_imm(out_imm_16), .out_illegal(out_illegal_16)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_kind(input logic [31:0] ins);
    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] fn;
    op = ins[31:26];
    rt = ins[20:16];
    fn = ins[5:0];
    if (op == 6'h00 && fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B,
                                  6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h09}) return 2'b00;
    if (op inside {6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h24}) return 2'b00;
    if (op == 6'h00 && fn inside {6'h2A, 6'h03, 6'h07}) return 2'b01;
    if (op == 6'h01 && rt <= 5'd1) return 2'b01;
    if (op inside {6'h09, 6'h0A, 6'h04, 6'h05, 6'h06, 6'h07, 6'h20, 6'h28, 6'h23, 6'h2B})
      return 2'b01;
    if (op == 6'h0F) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic [31:0] ref_imm32(input logic [1:0] k, input logic [15:0] imm);
    case (k)
      2'b00:   return 32'(imm);
      2'b01:   return imm[15] ? 32'(imm) + 32'hFFFF0000 : 32'(imm);
      2'b10:   return 32'(imm) * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [15:0] ref_imm16(input logic [1:0] k, input logic [15:0] imm);
    return (k == 2'b11) ? 16'd0 : imm;
  endfunction

  logic        m_valid;
  logic [1:0]  m_kind;
  logic [31:0] m_imm32;
  logic [15:0] m_imm16;
  int          m_cnt;

  // advance the model by one clock using the inputs currently applied
  task automatic model_clock();
    logic rdy;
    logic acc;
    rdy = !m_valid || out_ready;
    acc = in_valid && rdy && !flush;
    if (rst) begin
      m_valid = 1'b0;
      m_cnt   = 0;
    end else begin
      if (acc && ref_kind(in_instr) == 2'b11) m_cnt++;
      if (flush) m_valid = 1'b0;
      else if (acc) begin
        m_valid = 1'b1;
        m_kind  = ref_kind(in_instr);
        m_imm32 = ref_imm32(m_kind, in_instr[15:0]);
        m_imm16 = ref_imm16(m_kind, in_instr[15:0]);
      end else if (m_valid && out_ready) m_valid = 1'b0;
    end
  endtask

  logic [5:0] fpool [8] = '{6'h21, 6'h2A, 6'h00, 6'h07, 6'h20, 6'h09, 6'h3F, 6'h03};
  logic [5:0] opool [12] = '{6'h09, 6'h0D, 6'h0F, 6'h02, 6'h03, 6'h24, 6'h2B,
                             6'h0B, 6'h04, 6'h3F, 6'h28, 6'h0E};

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins;
    int sel;
    ins = $urandom;
    sel = $urandom_range(0, 9);
    if (sel <= 2) begin
      ins[31:26] = 6'h00;
      ins[5:0]   = fpool[$urandom_range(0, 7)];
    end else if (sel == 3) begin
      ins[31:26] = 6'h01;
      ins[20:16] = 5'($urandom_range(0, 3));
    end else if (sel <= 7) begin
      ins[31:26] = opool[$urandom_range(0, 11)];
    end
    return ins;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h2408FFFC, 1'b1, 1'b1);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", in_ready); else n_pass++;
    n_total++; if (out_imm !== 32'd0) $display("FAIL reset_imm got %h want 0", out_imm); else n_pass++;
    n_total++; if (out_ext_op !== 2'b00) $display("FAIL reset_op got %b want 00", out_ext_op); else n_pass++;
    n_total++; if (out_illegal !== 1'b0) $display("FAIL reset_ill got %0b want 0", out_illegal); else n_pass++;
`ifdef EXT_ERR_CNT_EN
    n_total++; if (illegal_cnt !== 8'd0) $display("FAIL reset_cnt got %0d want 0", illegal_cnt); else n_pass++;
`endif
  endtask

  task automatic test_addiu();
    drive(1'b1, 32'h2408FFFC, 1'b1, 1'b0);
    n_total++; if (out_valid !== 1'b1) $display("FAIL addiu_valid got %0b want 1", out_valid); else n_pass++;
    n_total++; if (out_ext_op !== 2'b01) $display("FAIL addiu_op got %b want 01", out_ext_op); else n_pass++;
    n_total++; if (out_imm !== 32'hFFFFFFFC) $display("FAIL addiu_imm got %h want fffffffc", out_imm); else n_pass++;
    n_total++; if (out_illegal !== 1'b0) $display("FAIL addiu_ill got %0b want 0", out_illegal); else n_pass++;
    n_total++; if (out_imm_16 !== 16'hFFFC) $display("FAIL addiu_imm16 got %h want fffc", out_imm_16); else n_pass++;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    n_total++; if (out_valid !== 1'b0) $display("FAIL addiu_drain got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h3508FFFC, 1'b1, 1'b0);
    n_total++; if (out_ext_op !== 2'b00 || out_imm !== 32'h0000FFFC)
      $display("FAIL b2b_ori got %b/%h want 00/0000fffc", out_ext_op, out_imm); else n_pass++;
    in_instr = 32'h3C081234;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready got %0b want 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b1 || out_ext_op !== 2'b10 || out_imm !== 32'h12340000)
      $display("FAIL b2b_lui got %0b/%b/%h want 1/10/12340000", out_valid, out_ext_op, out_imm); else n_pass++;
    n_total++; if (out_imm_16 !== 16'h1234) $display("FAIL lui_imm16 got %h want 1234", out_imm_16); else n_pass++;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h2408FFFC, 1'b1, 1'b0);
    in_valid = 1'b1; in_instr = 32'h2D088000; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (in_ready !== 1'b0) $display("FAIL stall_ready got %0b want 0", in_ready); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (out_valid !== 1'b1 || out_ext_op !== 2'b01 || out_imm !== 32'hFFFFFFFC)
        $display("FAIL stall_hold got %0b/%b/%h want 1/01/fffffffc", out_valid, out_ext_op, out_imm); else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL release_ready got %0b want 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b1 || out_ext_op !== 2'b00 || out_imm !== 32'h00008000)
      $display("FAIL sltiu got %0b/%b/%h want 1/00/00008000", out_valid, out_ext_op, out_imm); else n_pass++;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    rst = 1'b0;
    drive(1'b1, 32'h08000010, 1'b1, 1'b0);
    n_total++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_ext_op !== 2'b11 || out_imm !== 32'd0)
      $display("FAIL jump_ill got %0b/%0b/%b/%h want 1/1/11/0", out_valid, out_illegal, out_ext_op, out_imm); else n_pass++;
    drive(1'b1, 32'h3108ABCD, 1'b0, 1'b1);
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %0b want 0", out_valid); else n_pass++;
`ifdef EXT_ERR_CNT_EN
    n_total++; if (illegal_cnt !== 8'd1) $display("FAIL flush_cnt got %0d want 1", illegal_cnt); else n_pass++;
`endif
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_drop got %0b want 0", out_valid); else n_pass++;
  endtask

`ifdef EXT_ERR_CNT_EN
  task automatic test_cnt_sat();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h0C000000 + 32'(i), 1'b1, 1'b0);
    n_total++; if (illegal_cnt_sat !== 2'd3) $display("FAIL sat_cnt got %0d want 3", illegal_cnt_sat); else n_pass++;
    n_total++; if (illegal_cnt !== 8'd5) $display("FAIL cnt5 got %0d want 5", illegal_cnt); else n_pass++;
    rst = 1'b1;
    drive(1'b1, 32'h08000000, 1'b1, 1'b0);
    rst = 1'b0;
    n_total++; if (illegal_cnt_sat !== 2'd0 || illegal_cnt !== 8'd0)
      $display("FAIL cnt_rst got %0d/%0d want 0/0", illegal_cnt_sat, illegal_cnt); else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic exp_rdy;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    rst = 1'b0;
    m_valid = 1'b0; m_kind = 2'b00; m_imm32 = 32'd0; m_imm16 = 16'd0; m_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = gen_instr();
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      exp_rdy = !m_valid || out_ready;
      n_total++; if (in_ready !== exp_rdy || in_ready_16 !== exp_rdy)
        $display("FAIL rnd_ready cyc %0d got %0b/%0b want %0b", i, in_ready, in_ready_16, exp_rdy); else n_pass++;
      model_clock();
      @(posedge clk); #1;
      n_total++; if (out_valid !== m_valid || out_valid_16 !== m_valid)
        $display("FAIL rnd_valid cyc %0d got %0b/%0b want %0b", i, out_valid, out_valid_16, m_valid); else n_pass++;
      if (m_valid) begin
        n_total++; if (out_ext_op !== m_kind || out_imm !== m_imm32 || out_illegal !== (m_kind == 2'b11))
          $display("FAIL rnd_data cyc %0d got %b/%h/%0b want %b/%h", i, out_ext_op, out_imm, out_illegal, m_kind, m_imm32);
        else n_pass++;
        n_total++; if (out_ext_op_16 !== m_kind || out_imm_16 !== m_imm16)
          $display("FAIL rnd_data16 cyc %0d got %b/%h want %b/%h", i, out_ext_op_16, out_imm_16, m_kind, m_imm16);
        else n_pass++;
      end
`ifdef EXT_ERR_CNT_EN
      n_total++; if (illegal_cnt !== 8'((m_cnt > 255) ? 255 : m_cnt) || illegal_cnt_sat !== 2'((m_cnt > 3) ? 3 : m_cnt))
        $display("FAIL rnd_cnt cyc %0d got %0d/%0d want %0d", i, illegal_cnt, illegal_cnt_sat, m_cnt); else n_pass++;
`endif
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_addiu();
    test_back_to_back();
    test_stall();
    test_flush();
`ifdef EXT_ERR_CNT_EN
    test_cnt_sat();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
